frame_encoder: RTL and testbench

Egress-side counterpart of the switch's frame decoder. It takes a raw 32-bit AXI-Stream payload plus a destination port bitmap and emits an encapsulated frame: a header word carrying the bitmap, the payload beats unchanged, and a trailer word carrying the payload byte count. Frames with an empty bitmap are discarded and counted as errors. It sits between a host or local source and the receive AXIS input of the switch wrapper, so its output is exactly the format the frame decoder consumes.

---
 rtl/frame_encoder.sv | 124 ++++++++++++
 tb/tb_frame_encoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_encoder.sv
// Egress frame encapsulator: wraps a raw AXI-Stream payload in a bitmap header
// and a byte-count trailer; frames with an empty destination bitmap are dropped.
module frame_encoder #(
  parameter int unsigned PORT_NUM = 4
) (
  input  logic                glb_clk,
  input  logic                glb_areset_n,
  input  logic                fe_s_axis_tvalid,
  output logic                fe_s_axis_tready,
  input  logic [31:0]         fe_s_axis_tdata,
  input  logic [3:0]          fe_s_axis_tkeep,
  input  logic                fe_s_axis_tlast,
  input  logic [PORT_NUM-1:0] fe_dst_sel_bits,
  output logic                fe_m_axis_tvalid,
  input  logic                fe_m_axis_tready,
  output logic [31:0]         fe_m_axis_tdata,
  output logic [3:0]          fe_m_axis_tkeep,
  output logic                fe_m_axis_tlast,
  output logic [31:0]         fe_frame_cnt,
  output logic [15:0]         fe_err_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned KEEP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TRL,
    S_DROP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic             reg_free_c;
  logic             s_hs_c;
  logic [CNT_W:0]   byte_sum_c;
  logic [CNT_W-1:0] byte_next_c;

  assign reg_free_c = !fe_m_axis_tvalid || fe_m_axis_tready;

  // Upstream ready: streaming only in DATA (gated by the output stage), sink in DROP.
  always_comb begin
    fe_s_axis_tready = 1'b0;
    case (state)
      S_DATA:  fe_s_axis_tready = reg_free_c;
      S_DROP:  fe_s_axis_tready = 1'b1;
      default: fe_s_axis_tready = 1'b0;
    endcase
  end

  assign s_hs_c = fe_s_axis_tvalid && fe_s_axis_tready;

  // Saturating byte accumulation; tkeep is contiguous so popcount equals byte count.
  always_comb begin
    byte_sum_c  = (CNT_W+1)'(byte_cnt) + (CNT_W+1)'($countones(fe_s_axis_tkeep));
    byte_next_c = byte_sum_c[CNT_W] ? {CNT_W{1'b1}} : byte_sum_c[CNT_W-1:0];
  end

  always_ff @(posedge glb_clk or negedge glb_areset_n) begin
    if (!glb_areset_n) begin
      state            <= S_IDLE;
      byte_cnt         <= '0;
      fe_m_axis_tvalid <= 1'b0;
      fe_m_axis_tdata  <= '0;
      fe_m_axis_tkeep  <= '0;
      fe_m_axis_tlast  <= 1'b0;
      fe_frame_cnt     <= '0;
      fe_err_cnt       <= '0;
    end else begin
      // A free output register retires its beat unless reloaded below.
      if (reg_free_c) fe_m_axis_tvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (fe_s_axis_tvalid) begin
            byte_cnt <= '0;
            if (fe_dst_sel_bits == '0) begin
              state <= S_DROP;
            end else if (reg_free_c) begin
              fe_m_axis_tvalid <= 1'b1;
              fe_m_axis_tdata  <= {8'hA5, 8'h00, 16'(fe_dst_sel_bits)};
              fe_m_axis_tkeep  <= {KEEP_W{1'b1}};
              fe_m_axis_tlast  <= 1'b0;
              state            <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (s_hs_c) begin
            fe_m_axis_tvalid <= 1'b1;
            fe_m_axis_tdata  <= fe_s_axis_tdata;
            fe_m_axis_tkeep  <= fe_s_axis_tkeep;
            fe_m_axis_tlast  <= 1'b0;
            byte_cnt         <= byte_next_c;
            if (fe_s_axis_tlast) state <= S_TRL;
          end
        end

        S_TRL: begin
          if (reg_free_c) begin
            fe_m_axis_tvalid <= 1'b1;
            fe_m_axis_tdata  <= {16'h5A5A, byte_cnt};
            fe_m_axis_tkeep  <= {KEEP_W{1'b1}};
            fe_m_axis_tlast  <= 1'b1;
            fe_frame_cnt     <= fe_frame_cnt + 32'd1;
            state            <= S_IDLE;
          end
        end

        S_DROP: begin
          if (s_hs_c && fe_s_axis_tlast) begin
            if (fe_err_cnt != 16'hFFFF) fe_err_cnt <= fe_err_cnt + 16'd1;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_encoder.sv
// Scoreboard bench for frame_encoder: a frame-level model queues expected output
// beats, a monitor pops and compares them on every output handshake.
module tb_frame_encoder;

  localparam int unsigned PN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [31:0]   s_tdata = '0;
  logic [3:0]    s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic [PN-1:0] dst = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [31:0]   m_tdata;
  logic [3:0]    m_tkeep;
  logic          m_tlast;
  logic [31:0]   frame_cnt;
  logic [15:0]   err_cnt;

  frame_encoder #(.PORT_NUM(PN)) dut (
    .glb_clk          (clk),
    .glb_areset_n     (rst_n),
    .fe_s_axis_tvalid (s_tvalid),
    .fe_s_axis_tready (s_tready),
    .fe_s_axis_tdata  (s_tdata),
    .fe_s_axis_tkeep  (s_tkeep),
    .fe_s_axis_tlast  (s_tlast),
    .fe_dst_sel_bits  (dst),
    .fe_m_axis_tvalid (m_tvalid),
    .fe_m_axis_tready (m_tready),
    .fe_m_axis_tdata  (m_tdata),
    .fe_m_axis_tkeep  (m_tkeep),
    .fe_m_axis_tlast  (m_tlast),
    .fe_frame_cnt     (frame_cnt),
    .fe_err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] pl_d[$];
  logic [3:0]  pl_k[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_frames = 0;
  int          exp_errs = 0;
  bit          mon_en = 1'b0;
  bit          bp_on = 1'b0;
  bit          hold_pend = 1'b0;
  beat_t       held;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one whole frame -> its encoded beat list.
  task automatic model_frame(input logic [PN-1:0] bm);
    int total;
    total = 0;
    if (bm == '0) begin
      if (exp_errs < 65535) exp_errs++;
    end else begin
      exp_q.push_back({{8'hA5, 8'h00, 16'(bm)}, 4'hF, 1'b0});
      foreach (pl_d[i]) begin
        exp_q.push_back({pl_d[i], pl_k[i], 1'b0});
        total += $countones(pl_k[i]);
      end
      if (total > 65535) total = 65535;
      exp_q.push_back({{16'h5A5A, 16'(total)}, 4'hF, 1'b1});
      exp_frames++;
    end
  endtask

  // Downstream ready: random when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    m_tready = bp_on ? 1'($urandom % 2) : 1'b1;
  end

  // Monitor: pops expected beats on handshakes and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        chk("stable", 64'({m_tvalid, m_tdata, m_tkeep, m_tlast}), 64'({1'b1, held}));
      hold_pend = m_tvalid && !m_tready;
      held      = {m_tdata, m_tkeep, m_tlast};
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", m_tdata, $time);
        end else begin
          chk("out_beat", 64'({m_tdata, m_tkeep, m_tlast}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_hs();
    int n;
    bit hs;
    n = 0;
    forever begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      if (hs) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL hs_timeout: got no tready expected handshake at %0t", $time);
        break;
      end
    end
  endtask

  task automatic drive_frame(input logic [PN-1:0] bm, input bit gaps, input bit change,
                             input logic [PN-1:0] new_bm);
    model_frame(bm);
    dst = bm;
    for (int i = 0; i < pl_d.size(); i++) begin
      s_tvalid = 1'b1;
      s_tdata  = pl_d[i];
      s_tkeep  = pl_k[i];
      s_tlast  = (i == pl_d.size() - 1);
      wait_hs();
      if (change && i == 0) dst = new_bm;
      s_tvalid = 1'b0;
      if (gaps) repeat ($urandom % 3) begin @(posedge clk); #1; end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load_normal();
    pl_d = {32'h11111111, 32'h22222222, 32'h33333333};
    pl_k = {4'hF, 4'hF, 4'h3};
  endtask

  initial begin
    logic [3:0] kopts [5];
    kopts = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};

    #3 rst_n = 1'b0;
    #2;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Normal frame, no backpressure
    load_normal();
    drive_frame(4'b0010, 1'b0, 1'b0, 4'b0010);
    wait_drain();
    chk("normal_frame_cnt", 64'(frame_cnt), 64'd1);

    // Drop then a good frame
    pl_d = {32'hDEADBEEF, 32'hCAFEF00D};
    pl_k = {4'hF, 4'hF};
    drive_frame(4'b0000, 1'b0, 1'b0, 4'b0000);
    repeat (4) @(posedge clk); #1;
    chk("drop_err_cnt", 64'(err_cnt), 64'd1);
    load_normal();
    drive_frame(4'b0100, 1'b0, 1'b0, 4'b0100);
    wait_drain();

    // Backpressure on the normal frame
    bp_on = 1'b1;
    load_normal();
    drive_frame(4'b0010, 1'b1, 1'b0, 4'b0010);
    wait_drain();

    // Bitmap change mid-frame
    load_normal();
    drive_frame(4'b0001, 1'b0, 1'b1, 4'b1000);
    wait_drain();

    // Randomised frames
    for (int f = 0; f < 40; f++) begin
      logic [PN-1:0] bm;
      int len;
      bm  = ($urandom % 4 == 0) ? '0 : PN'($urandom_range(1, 15));
      len = $urandom_range(1, 5);
      pl_d.delete();
      pl_k.delete();
      for (int i = 0; i < len; i++) begin
        pl_d.push_back($urandom);
        pl_k.push_back(kopts[$urandom_range(0, 4)]);
      end
      drive_frame(bm, 1'b1, 1'b1, PN'($urandom));
    end
    wait_drain();
    chk("rand_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    chk("rand_err_cnt", 64'(err_cnt), 64'(exp_errs));

    // Reset mid-frame
    bp_on  = 1'b0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    dst      = 4'b0001;
    s_tvalid = 1'b1;
    s_tdata  = 32'h01234567;
    s_tkeep  = 4'hF;
    s_tlast  = 1'b0;
    wait_hs();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_tdata", 64'(m_tdata), 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    s_tvalid = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_errs   = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    load_normal();
    drive_frame(4'b1001, 1'b0, 1'b0, 4'b1001);
    wait_drain();
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);

    // Byte count saturation: 16384 full beats
    pl_d.delete();
    pl_k.delete();
    for (int i = 0; i < 16384; i++) begin
      pl_d.push_back($urandom);
      pl_k.push_back(4'hF);
    end
    drive_frame(4'b0110, 1'b0, 1'b0, 4'b0110);
    wait_drain();
    chk("sat_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    chk("sat_err_cnt", 64'(err_cnt), 64'(exp_errs));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
